pcm_byte_unpacker: RTL
======================

Name: pcm_byte_unpacker

Overview:
- Synthesisable byte-stream to word assembler for PCM sample streams, such as WAV payloads from the SD/flash loader and the host byte pipe.
- Packs 1..MAX_WORD_BYTES bytes per word, with selectable endianness, and tags each word with an interleaved channel index.
- Keeps a running accepted-byte count.
- Sits between the byte source and the per-channel sample FIFOs feeding the audio path.

Parameters:
- MAX_WORD_BYTES, 4, maximum bytes per word; output width = 8*MAX_WORD_BYTES (legal 1..4).
- NUM_CHANNELS, 2, interleaved channel count (legal 1..16).
- CNT_W, 32, width of the accepted-byte counter.

Ports:
- clk_ir  in  1  system clock
- rst_ih  in  1  synchronous active-high reset
- cfg_word_bytes_i  in  3  bytes per word, sampled at the first byte of each word; 0 or >MAX_WORD_BYTES treated as MAX_WORD_BYTES
- cfg_big_endian_i  in  1  1 = first byte is MSB; 0 = first byte is LSB
- clear_i  in  1  synchronous clear of counter, channel index and partial word
- in_data_i  in  8  input byte
- in_valid_i  in  1  input byte valid
- in_last_i  in  1  last byte of stream, qualified by in_valid_i
- in_ready_o  out  1  input byte accepted when valid && ready
- out_data_o  out  8*MAX_WORD_BYTES  assembled word, unused upper bytes zero
- out_chan_o  out  $clog2(NUM_CHANNELS) min 1  channel index of word
- out_last_o  out  1  word contains the stream-last byte
- out_partial_o  out  1  word flushed short by in_last_i
- out_valid_o  out  1  word valid
- out_ready_i  in  1  downstream accept
- bytes_read_o  out  CNT_W  accepted bytes since reset/clear, saturating

Behaviour:
- Reset (rst_ih=1 on a clock edge): all outputs 0, including in_ready_o=0 during reset. FSM goes to IDLE. Byte index, channel index and counter all 0. in_ready_o=1 from the first cycle after reset deasserts.
- FSM IDLE: on byte accept, latch the effective word size N, place the byte at position 0, byte index=1, go to ACCUM. If N==1, or in_last_i is set, go directly to HOLD.
- FSM ACCUM: each accepted byte is placed at position byte index. When byte index reaches N-1, or in_last_i is set, go to HOLD.
- FSM HOLD: out_valid_o=1. On out_ready_i, go to IDLE, or directly to IDLE-with-new-byte if a byte is accepted the same cycle.
- Byte placement:
  - Little-endian: byte k goes to bits [8k+7:8k].
  - Big-endian: byte k goes to bits [8(N-1-k)+7:8(N-1-k)].
  - Bytes at positions >=N are 0.
- Partial flush: when in_last_i arrives before N bytes, unfilled bytes are 0 (positions computed with the latched N) and out_partial_o=1.
- Latency: out_valid_o asserts the cycle after the completing byte is accepted. Output is registered; no combinational in->out path.
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i.
  - A full word and the next first byte can transfer in the same cycle, giving 1 word per N cycles sustained.
  - out_data_o, out_chan_o, out_last_o and out_partial_o hold stable while out_valid_o && !out_ready_i.
- Channel index: increments on each output handshake and wraps from NUM_CHANNELS-1 to 0. It resets to 0 after a word with out_last_o is accepted.
- bytes_read_o: +1 per accepted byte and saturates at all-ones.
- clear_i: has priority over accepts in the same cycle. It drops any partial or held word (out_valid_o deasserts the next cycle) and zeroes the counter and channel index.
- cfg_* changes mid-word have no effect until the next word starts.

Optional Feature:
- Macro: PCM_UNPACK_SIGN_EXT_EN.
- When defined: a word with N<MAX_WORD_BYTES is sign-extended from bit 8N-1 into the upper bytes. This applies to both full and partial words, with sign taken after zero-fill.
- When undefined: upper bytes are zero and no sign-extension logic is built.

Decomposition:
- Shared package pcm_unpack_pkg:
  - FSM state enum (IDLE, ACCUM, HOLD)
  - localparam BYTE_W=8
  - function eff_word_bytes() for the 0/>MAX clamp
  - struct pcm_word_t {data, chan, last, partial}
- One natural sub-module: pcm_byte_placer, the combinational position/endianness/sign-extension mux that writes byte k into the word register.

Test Plan:
1. N=2, little-endian, 2 channels. Bytes 34 12 78 56, out_ready_i=1 throughout -> words 0x00001234 ch0 and 0x00005678 ch1, each 1 cycle after its 2nd byte; bytes_read_o=4.
2. N=4, big-endian. Bytes DE AD BE EF -> 0xDEADBEEF ch0, out_partial_o=0.
3. Backpressure. Hold out_ready_i=0 for 5 cycles with a word pending -> in_ready_o=0; out_data_o stable; no byte lost after release; back-to-back throughput 1 word/N cycles.
4. N=4, little-endian. Bytes 11 22 33 with in_last_i on 33 -> 0x00332211, partial=1, last=1; next word ch0. With PCM_UNPACK_SIGN_EXT_EN and N=2, bytes 00 80 -> 0xFFFF8000.
5. clear_i asserted mid-word and same-cycle with a byte -> byte discarded, out_valid_o=0, bytes_read_o=0, next word ch0.
6. CNT_W=4. Feed 20 bytes -> bytes_read_o saturates at 15. Reset mid-HOLD -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pcm_unpack_pkg.sv
// Purpose : shared types, constants and helpers for the PCM byte unpacker.
// Latency : n/a (types and functions only).
// Backpr. : n/a.
// Contents: pcm_state_e (IDLE/ACCUM/HOLD), BYTE_W, pcm_word_t output record,
//           eff_word_bytes() which clamps the configured word size.
package pcm_unpack_pkg;

    localparam int BYTE_W     = 8;
    // Upper bounds of the legal parameter ranges, used to size pcm_word_t.
    localparam int MAX_DATA_W = 32;
    localparam int MAX_CHAN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } pcm_state_e;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_CHAN_W-1:0] chan;
        logic                  last;
        logic                  partial;
    } pcm_word_t;

    // A word size of 0, or larger than the instance supports, means "full width".
    function automatic logic [2:0] eff_word_bytes(input logic [2:0]  cfg,
                                                  input int unsigned max_bytes);
        if (cfg == 3'd0 || {29'd0, cfg} > max_bytes) begin
            return 3'(max_bytes);
        end
        return cfg;
    endfunction

endpackage

// File: rtl/pcm_byte_placer.sv
// Purpose : combinational placement of one byte into a partially built word,
//           honouring endianness and the latched word size.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller decides when the result is registered.
// Ports   : word_i  current word contents (zero for the first byte of a word)
//           byte_i  byte to insert, idx_i its index within the word
//           n_i     effective bytes per word (1..MAX_WORD_BYTES)
//           big_endian_i  1 = byte 0 lands in the most significant used byte
//           word_o  word with the byte inserted (and sign-extended if enabled)
// Option  : PCM_UNPACK_SIGN_EXT_EN replicates bit 8N-1 into the bytes above N.
module pcm_byte_placer
    import pcm_unpack_pkg::*;
#(
    parameter int MAX_WORD_BYTES = 4
) (
    input  logic [BYTE_W*MAX_WORD_BYTES-1:0] word_i,
    input  logic [BYTE_W-1:0]                byte_i,
    input  logic [2:0]                       idx_i,
    input  logic [2:0]                       n_i,
    input  logic                             big_endian_i,
    output logic [BYTE_W*MAX_WORD_BYTES-1:0] word_o
);

    logic [2:0] pos;
`ifdef PCM_UNPACK_SIGN_EXT_EN
    logic       sign;
`endif

    always_comb begin
        word_o = word_i;
        pos    = big_endian_i ? (n_i - 3'd1 - idx_i) : idx_i;
        for (int k = 0; k < MAX_WORD_BYTES; k++) begin
            if (3'(k) == pos) begin
                word_o[BYTE_W*k +: BYTE_W] = byte_i;
            end
        end
`ifdef PCM_UNPACK_SIGN_EXT_EN
        // Bytes >= N are never written, so extending on every byte is harmless:
        // the value seen once the word completes is the one that matters.
        sign = 1'b0;
        for (int k = 0; k < MAX_WORD_BYTES; k++) begin
            if (3'(k + 1) == n_i) begin
                sign = word_o[BYTE_W*k + BYTE_W - 1];
            end
        end
        for (int k = 0; k < MAX_WORD_BYTES; k++) begin
            if (3'(k) >= n_i) begin
                word_o[BYTE_W*k +: BYTE_W] = {BYTE_W{sign}};
            end
        end
`endif
    end

endmodule

// File: rtl/pcm_byte_unpacker.sv
// Purpose : assembles a PCM byte stream into 1..MAX_WORD_BYTES-byte words tagged
//           with an interleaved channel index; counts accepted bytes (saturating).
// Latency : word valid 1 cycle after its completing byte is accepted; all outputs registered.
// Backpr. : in_ready_o = !out_valid_o || out_ready_i, so a word drains and the next
//           word's first byte enters in the same cycle (1 word per N cycles sustained).
// Ports   : clk_ir/rst_ih clock and sync active-high reset; clear_i drops the word,
//           zeroes counter and channel; cfg_* sampled on the first byte of a word;
//           in_* byte input; out_* word output; bytes_read_o accepted-byte count.
// Option  : PCM_UNPACK_SIGN_EXT_EN sign-extends words shorter than MAX_WORD_BYTES.
module pcm_byte_unpacker
    import pcm_unpack_pkg::*;
#(
    parameter int MAX_WORD_BYTES = 4,
    parameter int NUM_CHANNELS   = 2,
    parameter int CNT_W          = 32,
    localparam int DATA_W = BYTE_W * MAX_WORD_BYTES,
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic              clk_ir,
    input  logic              rst_ih,
    input  logic [2:0]        cfg_word_bytes_i,
    input  logic              cfg_big_endian_i,
    input  logic              clear_i,
    input  logic [BYTE_W-1:0] in_data_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CH_W-1:0]   out_chan_o,
    output logic              out_last_o,
    output logic              out_partial_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  bytes_read_o
);

    pcm_state_e        state_q;
    logic [2:0]        n_q;
    logic              be_q;
    logic [2:0]        idx_q;
    logic [DATA_W-1:0] data_q;
    logic [CH_W-1:0]   chan_q;
    logic              last_q;
    logic              partial_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              out_hs;
    logic              word_start;
    logic              word_done;
    logic [2:0]        n_d;
    logic              be_d;
    logic [2:0]        idx_cur;
    logic [2:0]        idx_d;
    logic [DATA_W-1:0] base_word;
    logic [DATA_W-1:0] data_d;
    logic [CH_W-1:0]   chan_d;

    assign out_valid_o   = (state_q == ST_HOLD);
    // Forced low while reset is asserted so the source never sees a phantom accept.
    assign in_ready_o    = !rst_ih && (!out_valid_o || out_ready_i);
    assign out_data_o    = data_q;
    assign out_chan_o    = chan_q;
    assign out_last_o    = last_q;
    assign out_partial_o = partial_q;
    assign bytes_read_o  = cnt_q;

    assign accept = in_valid_i && in_ready_o && !clear_i;
    assign out_hs = out_valid_o && out_ready_i;

    always_comb begin
        // Outside ACCUM any accepted byte begins a fresh word (IDLE, or HOLD draining).
        word_start = (state_q != ST_ACCUM);
        n_d        = word_start ? eff_word_bytes(cfg_word_bytes_i, MAX_WORD_BYTES) : n_q;
        be_d       = word_start ? cfg_big_endian_i : be_q;
        idx_cur    = word_start ? 3'd0 : idx_q;
        base_word  = word_start ? '0 : data_q;
        idx_d      = idx_cur + 3'd1;
        word_done  = (idx_d == n_d) || in_last_i;
        chan_d     = (last_q || chan_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : chan_q + CH_W'(1);
    end

    pcm_byte_placer #(
        .MAX_WORD_BYTES (MAX_WORD_BYTES)
    ) u_placer (
        .word_i       (base_word),
        .byte_i       (in_data_i),
        .idx_i        (idx_cur),
        .n_i          (n_d),
        .big_endian_i (be_d),
        .word_o       (data_d)
    );

    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            state_q   <= ST_IDLE;
            n_q       <= 3'd0;
            be_q      <= 1'b0;
            idx_q     <= 3'd0;
            data_q    <= '0;
            chan_q    <= '0;
            last_q    <= 1'b0;
            partial_q <= 1'b0;
            cnt_q     <= '0;
        end else if (clear_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            data_q    <= '0;
            chan_q    <= '0;
            last_q    <= 1'b0;
            partial_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (out_hs) begin
                chan_q <= chan_d;
                if (!accept) begin
                    state_q <= ST_IDLE;
                end
            end
            if (accept) begin
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                data_q    <= data_d;
                n_q       <= n_d;
                be_q      <= be_d;
                idx_q     <= idx_d;
                last_q    <= in_last_i;
                partial_q <= in_last_i && (idx_d != n_d);
                state_q   <= word_done ? ST_HOLD : ST_ACCUM;
            end
        end
    end

endmodule
